// File: rtl/bus_writeback_demux_if.sv
// bus_writeback_demux_if: control-unit side bundle for the writeback demux (commands in, register values and status out)
interface bus_writeback_demux_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0] bus_in;
    logic [2:0]       dest;
    logic             ld_en;
    logic [5:0]       inc;
    logic [5:0]       clr;
    logic [WIDTH-1:0] L_out;
    logic [WIDTH-1:0] W_out;
    logic [WIDTH-1:0] K_out;
    logic [WIDTH-1:0] T_out;
    logic [WIDTH-1:0] X_out;
    logic [WIDTH-1:0] J_out;
    logic             wr_ack;
    logic             wr_err;
    logic [2:0]       last_dest;

    modport master (
        output bus_in, dest, ld_en, inc, clr,
        input  L_out, W_out, K_out, T_out, X_out, J_out, wr_ack, wr_err, last_dest
    );

    modport slave (
        input  bus_in, dest, ld_en, inc, clr,
        output L_out, W_out, K_out, T_out, X_out, J_out, wr_ack, wr_err, last_dest
    );
endinterface

// File: rtl/bus_writeback_demux.sv
// bus_writeback_demux: writes the shared bus into one of six datapath registers (L,W,K,T,X,J) with per-register inc/clr
module bus_writeback_demux #(
    parameter int WIDTH    = 24,
    parameter int INC_STEP = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bus_writeback_demux_if.slave  b
);
    localparam logic [WIDTH-1:0] STEP = WIDTH'(INC_STEP);

    // Register slots in inc/clr bit order: 0 L, 1 W, 2 K, 3 T, 4 X, 5 J
    logic [5:0][WIDTH-1:0] reg_q, reg_d;
    logic [5:0]            sel;
    logic                  valid;
    logic                  wr_ack_q, wr_ack_d;
    logic                  wr_err_q, wr_err_d;
    logic [2:0]            last_dest_q, last_dest_d;

    // Decode dest into a one-hot load select; per register clr beats load beats inc beats hold
    always_comb begin
        sel = {b.dest == 3'b110, b.dest == 3'b101, b.dest == 3'b001,
               b.dest == 3'b011, b.dest == 3'b010, b.dest == 3'b111} & {6{b.ld_en}};
        valid = |sel;
        for (int i = 0; i < 6; i++)
            reg_d[i] = b.clr[i] ? '0 : sel[i] ? b.bus_in : b.inc[i] ? reg_q[i] + STEP : reg_q[i];
        wr_ack_d    = valid;
        wr_err_d    = b.ld_en & ~valid;
        last_dest_d = valid ? b.dest : last_dest_q;
    end

    // State and status flops, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q       <= '0;
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            last_dest_q <= 3'b000;
        end else begin
            reg_q       <= reg_d;
            wr_ack_q    <= wr_ack_d;
            wr_err_q    <= wr_err_d;
            last_dest_q <= last_dest_d;
        end
    end

    assign b.L_out     = reg_q[0];
    assign b.W_out     = reg_q[1];
    assign b.K_out     = reg_q[2];
    assign b.T_out     = reg_q[3];
    assign b.X_out     = reg_q[4];
    assign b.J_out     = reg_q[5];
    assign b.wr_ack    = wr_ack_q;
    assign b.wr_err    = wr_err_q;
    assign b.last_dest = last_dest_q;
endmodule
